memory_controller: RTL and testbench
====================================

# memory_controller

Shared main-memory responder that sits on the far side of the cache-to-memory interface and serves two caches. It accepts 33-bit memory requests from each cache, arbitrates round-robin, and models memory latency. It returns 16-bit block data with a one-cycle ready pulse. On every write it broadcasts the written address to the other cache so that cache can invalidate its copy.

## Interface
- WORD_ADDR_BITS, 8, number of word-index bits; the array holds 2^WORD_ADDR_BITS 16-bit words.
- MEM_LATENCY, 2, BUSY cycles between accept and response; legal values are 1 to 15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- memory_request_0 / memory_request_1  in  33  bit 32 selects the operation (0 = read, 1 = write); bits 31:16 are write data; bits 15:0 are the address.
- memory_request_ready_0 / _1  in  1  the request is valid; the cache holds it high until it sees a response.
- memory_response_0 / _1  out  16  block data returned to that cache.
- memory_response_ready_0 / _1  out  1  one-cycle pulse; memory_response_N is valid in the same cycle.
- invalidate_address_N  out  16  address written by the other port.
- invalidate_valid_N  out  1  one-cycle strobe that qualifies invalidate_address_N.

## Operation
- Word index is address[WORD_ADDR_BITS:1].
  - address[0] (the byte offset) is ignored.
  - Address bits above WORD_ADDR_BITS are ignored, so those addresses alias.
- Read: return the whole 16-bit word.
- Write: store request bits 31:16 into the word. The response carries the written data.
- States:
  - IDLE: arbitrate among eligible ports. A port is eligible when its request_ready is 1 and its armed flag is 1. On a grant, latch the request, port number and operation; clear the granted port's armed flag; load the latency counter with MEM_LATENCY; go to BUSY. With no eligible port, stay in IDLE.
  - BUSY: decrement the counter. When the counter reaches 1, go to RESPOND, and at that same edge do the array write or the array read into the response register.
  - RESPOND: assert memory_response_ready_p for exactly one cycle. If the operation is a write, also assert invalidate_valid_q and invalidate_address_q for the other port q in the same cycle. Return to IDLE.
- Re-arm: a port's armed flag is set again on any edge where that port's request_ready is sampled 0. A request held high after its response is never served twice.
- Arbitration:
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port that is not last_grant; then update last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- Requests are fully serialized, so a read always observes every earlier-completed write, including one from the other port.
- memory_response_N holds its last value until the next response to port N.
- A request whose fields change while it waits in BUSY has no effect: the latched copy is used.

## Timing
- Reset values (all asserted immediately and asynchronously):
  - All outputs are 0.
  - State = IDLE, counter = 0, armed flags = 1, last_grant = 1.
  - Array contents are not cleared.
- Reset mid-transaction: the in-flight transaction is dropped.
  - No response or invalidate pulse follows.
  - A write whose array update edge has not yet occurred is not performed.
- Latency: request accepted at edge A.
  - Array access happens at edge A+MEM_LATENCY.
  - The response pulse spans cycle A+MEM_LATENCY to A+MEM_LATENCY+1.
  - The next accept is possible at edge A+MEM_LATENCY+2 at the earliest.
  - Minimum period is MEM_LATENCY+2 cycles per transaction.
- Response and invalidate pulses are registered outputs with no combinational path from the inputs.
- A request asserted on port 1 while port 0 is in BUSY waits. It is granted in the next IDLE cycle.

## Test plan
- **Write, invalidate, read:** use MEM_LATENCY=2. Port 0 sends {1, 16'hBEEF, 16'h0010}, accepted at edge A.
  - Required: memory_response_ready_0 is high only in cycle A+2, with memory_response_0=16'hBEEF.
  - Required: invalidate_valid_1=1 and invalidate_address_1=16'h0010 in the same cycle; invalidate_valid_0 stays 0.
  - Then port 1 reads 16'h0011 and must return 16'hBEEF.
- **Simultaneous reads after reset:** ports 0 and 1 both read, in the same cycle.
  - Required: port 0 responds first. Port 1 is accepted 4 cycles after port 0's accept and responds afterward.
  - Each response_ready pulse lasts exactly 1 cycle.
- **Held request:** port 0 keeps request_ready=1 for 10 cycles after its response.
  - Required: no second response pulse.
  - Dropping request_ready for 1 cycle, then reasserting it, yields exactly one new response.
- **Fairness:** both ports re-request immediately after every response for 6 transactions.
  - Required: the grant order is 0,1,0,1,0,1.
- **Aliasing:** with WORD_ADDR_BITS=8, write 16'h1234 to 16'h0202, then read 16'hFE02.
  - Required: the read returns 16'h1234.
- **Reset mid-operation:** port 1 writes 16'hAAAA to 16'h0004 after 16'h5555 has already been written there.
  - Assert reset during BUSY, before the array update edge.
  - Required: all outputs go to 0 immediately, with no later pulse.
  - After release, a read of 16'h0004 returns 16'h5555.

Source files
------------

// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// memory_controller
//
// Shared main-memory responder for two caches. Each cache presents a 33-bit
// request {write, data[15:0], address[15:0]} qualified by a level-sensitive
// ready line. Requests are served one at a time with round-robin arbitration
// and a fixed, configurable latency. Every response is a one-cycle pulse.
// A write also sends a one-cycle invalidate strobe, carrying the written
// address, to the *other* cache.
//
// Parameters
//   WORD_ADDR_BITS : number of word-index bits (array holds 2^N 16-bit words)
//   MEM_LATENCY    : BUSY cycles between accept and response (1..15)
//
// Ports
//   clock                      : rising-edge clock
//   reset                      : asynchronous, active-high reset
//   memory_request_0/1         : {op, wdata[15:0], addr[15:0]} from cache 0/1
//   memory_request_ready_0/1   : request valid, held until a response is seen
//   memory_response_0/1        : block data returned to cache 0/1
//   memory_response_ready_0/1  : one-cycle response pulse
//   invalidate_address_0/1     : address written by the other port
//   invalidate_valid_0/1       : one-cycle strobe qualifying the address
// ---------------------------------------------------------------------------
module memory_controller #(
   parameter int WORD_ADDR_BITS = 8,
   parameter int MEM_LATENCY    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [32:0] memory_request_0,
   input  logic [32:0] memory_request_1,
   input  logic        memory_request_ready_0,
   input  logic        memory_request_ready_1,
   output logic [15:0] memory_response_0,
   output logic [15:0] memory_response_1,
   output logic        memory_response_ready_0,
   output logic        memory_response_ready_1,
   output logic [15:0] invalidate_address_0,
   output logic [15:0] invalidate_address_1,
   output logic        invalidate_valid_0,
   output logic        invalidate_valid_1
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESPOND
   } state_t;

   localparam int         DEPTH        = 1 << WORD_ADDR_BITS;
   localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY);

   logic [15:0] memArray [DEPTH];

   state_t      state_q,      state_d;
   logic [3:0]  count_q,      count_d;
   logic [1:0]  armed_q,      armed_d;
   logic        lastGrant_q,  lastGrant_d;
   logic [32:0] req_q,        req_d;
   logic        port_q,       port_d;
   logic [15:0] resp0_q,      resp0_d;
   logic [15:0] resp1_q,      resp1_d;
   logic        respRdy0_q,   respRdy0_d;
   logic        respRdy1_q,   respRdy1_d;
   logic [15:0] invAddr0_q,   invAddr0_d;
   logic [15:0] invAddr1_q,   invAddr1_d;
   logic        invValid0_q,  invValid0_d;
   logic        invValid1_q,  invValid1_d;

   logic                      reqWrite;
   logic [15:0]               reqData;
   logic [15:0]               reqAddr;
   logic [WORD_ADDR_BITS-1:0] wordIdx;
   logic                      accessNow;
   logic [1:0]                eligible;
   logic                      grant;
   logic [15:0]               result;

   assign reqWrite  = req_q[32];
   assign reqData   = req_q[31:16];
   assign reqAddr   = req_q[15:0];
   assign wordIdx   = reqAddr[WORD_ADDR_BITS:1];
   assign accessNow = (state_q == BUSY) && (count_q == 4'd1);
   assign eligible  = {memory_request_ready_1 & armed_q[1],
                       memory_request_ready_0 & armed_q[0]};

   // Next-state logic. Response and invalidate pulses default to 0 so they
   // only live for the single cycle after the array access edge. A port is
   // re-armed whenever its ready line is seen low, which is what stops a
   // request that is still held high from being served a second time. In a
   // tie the port that did not win last time is granted.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      armed_d     = armed_q | ~{memory_request_ready_1, memory_request_ready_0};
      lastGrant_d = lastGrant_q;
      req_d       = req_q;
      port_d      = port_q;
      resp0_d     = resp0_q;
      resp1_d     = resp1_q;
      respRdy0_d  = 1'b0;
      respRdy1_d  = 1'b0;
      invAddr0_d  = invAddr0_q;
      invAddr1_d  = invAddr1_q;
      invValid0_d = 1'b0;
      invValid1_d = 1'b0;
      grant       = 1'b0;
      result      = 16'h0000;

      case (state_q)
         IDLE: begin
            if (|eligible) begin
               grant          = (&eligible) ? ~lastGrant_q : eligible[1];
               port_d         = grant;
               req_d          = grant ? memory_request_1 : memory_request_0;
               armed_d[grant] = 1'b0;
               lastGrant_d    = grant;
               count_d        = LATENCY_LOAD;
               state_d        = BUSY;
            end
         end

         BUSY: begin
            if (count_q == 4'd1) begin
               count_d = 4'd0;
               state_d = RESPOND;
               result  = reqWrite ? reqData : memArray[wordIdx];
               if (port_q == 1'b0) begin
                  resp0_d     = result;
                  respRdy0_d  = 1'b1;
                  invValid1_d = reqWrite;
                  if (reqWrite) begin
                     invAddr1_d = reqAddr;
                  end
               end else begin
                  resp1_d     = result;
                  respRdy1_d  = 1'b1;
                  invValid0_d = reqWrite;
                  if (reqWrite) begin
                     invAddr0_d = reqAddr;
                  end
               end
            end else begin
               count_d = count_q - 4'd1;
            end
         end

         RESPOND: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset is asynchronous, so an in-flight
   // transaction is dropped at once: state returns to IDLE before the array
   // update edge can arrive, and every output clears immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= 4'd0;
         armed_q     <= 2'b11;
         lastGrant_q <= 1'b1;
         req_q       <= 33'd0;
         port_q      <= 1'b0;
         resp0_q     <= 16'h0000;
         resp1_q     <= 16'h0000;
         respRdy0_q  <= 1'b0;
         respRdy1_q  <= 1'b0;
         invAddr0_q  <= 16'h0000;
         invAddr1_q  <= 16'h0000;
         invValid0_q <= 1'b0;
         invValid1_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         armed_q     <= armed_d;
         lastGrant_q <= lastGrant_d;
         req_q       <= req_d;
         port_q      <= port_d;
         resp0_q     <= resp0_d;
         resp1_q     <= resp1_d;
         respRdy0_q  <= respRdy0_d;
         respRdy1_q  <= respRdy1_d;
         invAddr0_q  <= invAddr0_d;
         invAddr1_q  <= invAddr1_d;
         invValid0_q <= invValid0_d;
         invValid1_q <= invValid1_d;
      end
   end

   // The storage array is deliberately not reset; it keeps its contents
   // across reset. The write is gated by the registered state, which reset
   // forces to IDLE, so an aborted write never lands.
   always_ff @(posedge clock) begin
      if (accessNow && reqWrite) begin
         memArray[wordIdx] <= reqData;
      end
   end

   assign memory_response_0       = resp0_q;
   assign memory_response_1       = resp1_q;
   assign memory_response_ready_0 = respRdy0_q;
   assign memory_response_ready_1 = respRdy1_q;
   assign invalidate_address_0    = invAddr0_q;
   assign invalidate_address_1    = invAddr1_q;
   assign invalidate_valid_0      = invValid0_q;
   assign invalidate_valid_1      = invValid1_q;

endmodule

// File: tb/tb_memory_controller.sv
// ---------------------------------------------------------------------------
// tb_memory_controller
//
// Directed bench for memory_controller (WORD_ADDR_BITS=8, MEM_LATENCY=2).
// Expected responses are queued as each request is driven; a negedge monitor
// pops them when a response pulse appears and checks the port, data and
// invalidate lines. The main sequence adds cycle-exact timing checks.
// ---------------------------------------------------------------------------
module tb_memory_controller;

   typedef struct {
      logic        port;
      logic [15:0] data;
      logic        inv;
      logic [15:0] invAddr;
   } expect_t;

   logic        clock;
   logic        reset;
   logic [32:0] req0;
   logic [32:0] req1;
   logic        rdy0;
   logic        rdy1;
   logic [15:0] resp0;
   logic [15:0] resp1;
   logic        respRdy0;
   logic        respRdy1;
   logic [15:0] invAddr0;
   logic [15:0] invAddr1;
   logic        invValid0;
   logic        invValid1;

   expect_t sb [$];
   expect_t monE;
   int      checks = 0;
   int      errors = 0;
   logic    prev0  = 1'b0;
   logic    prev1  = 1'b0;

   memory_controller #(
      .WORD_ADDR_BITS(8),
      .MEM_LATENCY   (2)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .memory_request_0       (req0),
      .memory_request_1       (req1),
      .memory_request_ready_0 (rdy0),
      .memory_request_ready_1 (rdy1),
      .memory_response_0      (resp0),
      .memory_response_1      (resp1),
      .memory_response_ready_0(respRdy0),
      .memory_response_ready_1(respRdy1),
      .invalidate_address_0   (invAddr0),
      .invalidate_address_1   (invAddr1),
      .invalidate_valid_0     (invValid0),
      .invalidate_valid_1     (invValid1)
   );

   // Free-running 10-time-unit clock; rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: every check in the bench funnels through here
   // so the counters and the FAIL report stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // All eight outputs must read zero (used right after reset is applied).
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rdy0"},  {31'd0, respRdy0},  32'd0);
      checkOutput({tag, "_rdy1"},  {31'd0, respRdy1},  32'd0);
      checkOutput({tag, "_resp0"}, {16'd0, resp0},     32'd0);
      checkOutput({tag, "_resp1"}, {16'd0, resp1},     32'd0);
      checkOutput({tag, "_iv0"},   {31'd0, invValid0}, 32'd0);
      checkOutput({tag, "_iv1"},   {31'd0, invValid1}, 32'd0);
      checkOutput({tag, "_ia0"},   {16'd0, invAddr0},  32'd0);
      checkOutput({tag, "_ia1"},   {16'd0, invAddr1},  32'd0);
   endtask

   // Pulse reset for one cycle; called and returns at posedge+1.
   task automatic applyReset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   // One complete transaction on one port: queue the expected result, raise
   // the request, wait (bounded) for its response pulse, then drop ready for
   // one edge so the port re-arms.
   task automatic applyStimulus(input logic port, input logic wr,
                                input logic [15:0] data, input logic [15:0] addr,
                                input logic [15:0] expData);
      expect_t e;
      logic    got;
      e.port    = port;
      e.data    = expData;
      e.inv     = wr;
      e.invAddr = addr;
      sb.push_back(e);
      if (port == 1'b0) begin
         req0 = {wr, data, addr};
         rdy0 = 1'b1;
      end else begin
         req1 = {wr, data, addr};
         rdy1 = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clock); #1;
         if ((port == 1'b0) ? respRdy0 : respRdy1) got = 1'b1;
      end
      checkOutput("respTimeout", {31'd0, got}, 32'd1);
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      @(posedge clock); #1;
   endtask

   // Scoreboard monitor, sampling on the falling edge: every response pulse
   // must match the oldest queued expectation, last exactly one cycle, and
   // carry the right invalidate on the opposite port.
   always @(negedge clock) begin
      if (respRdy0 || respRdy1) begin
         if (respRdy0) checkOutput("pulseWidth0", {31'd0, prev0}, 32'd0);
         if (respRdy1) checkOutput("pulseWidth1", {31'd0, prev1}, 32'd0);
         if (sb.size() == 0) begin
            checkOutput("unexpectedResp", {30'd0, respRdy1, respRdy0}, 32'd0);
         end else begin
            monE = sb.pop_front();
            checkOutput("respPort", {30'd0, respRdy1, respRdy0},
                        monE.port ? 32'd2 : 32'd1);
            checkOutput("respData", {16'd0, monE.port ? resp1 : resp0},
                        {16'd0, monE.data});
            if (monE.port) begin
               checkOutput("invValid0", {31'd0, invValid0}, {31'd0, monE.inv});
               checkOutput("invSelf1",  {31'd0, invValid1}, 32'd0);
               if (monE.inv) checkOutput("invAddr0", {16'd0, invAddr0}, {16'd0, monE.invAddr});
            end else begin
               checkOutput("invValid1", {31'd0, invValid1}, {31'd0, monE.inv});
               checkOutput("invSelf0",  {31'd0, invValid0}, 32'd0);
               if (monE.inv) checkOutput("invAddr1", {16'd0, invAddr1}, {16'd0, monE.invAddr});
            end
         end
      end else if (invValid0 || invValid1) begin
         checkOutput("strayInvalidate", {30'd0, invValid1, invValid0}, 32'd0);
      end
      prev0 = respRdy0;
      prev1 = respRdy1;
   end

   // Directed sequence: reset values, write/invalidate/read, aliasing,
   // simultaneous requests, held request, fairness and reset mid-write.
   initial begin
      expect_t e;
      int      cyc0;
      int      cyc1;
      int      pulses0;
      int      pulses1;
      int      order [6];
      int      served;
      int      s0;
      int      s1;

      reset = 1'b1;
      req0  = 33'd0;
      req1  = 33'd0;
      rdy0  = 1'b0;
      rdy1  = 1'b0;
      #2;
      checkAllZero("resetVal");
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      $display("[TB] write BEEF to 0010 from port 0");
      e.port = 1'b0; e.data = 16'hBEEF; e.inv = 1'b1; e.invAddr = 16'h0010;
      sb.push_back(e);
      req0 = {1'b1, 16'hBEEF, 16'h0010};
      rdy0 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clock); #1;
         checkOutput($sformatf("wrRdy0_c%0d", i), {31'd0, respRdy0}, (i == 3) ? 32'd1 : 32'd0);
         if (i == 3) begin
            checkOutput("wrResp0",  {16'd0, resp0},     32'h0000BEEF);
            checkOutput("wrInvV1",  {31'd0, invValid1}, 32'd1);
            checkOutput("wrInvA1",  {16'd0, invAddr1},  32'h00000010);
            checkOutput("wrInvV0",  {31'd0, invValid0}, 32'd0);
         end
      end
      rdy0 = 1'b0;
      @(posedge clock); #1;

      $display("[TB] port 1 reads 0011");
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0011, 16'hBEEF);
      checkOutput("crossRead", {16'd0, resp1}, 32'h0000BEEF);

      $display("[TB] aliasing");
      applyStimulus(1'b1, 1'b1, 16'h1234, 16'h0202, 16'h1234);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFE02, 16'h1234);
      checkOutput("aliasRead", {16'd0, resp0}, 32'h00001234);

      $display("[TB] simultaneous reads after reset, then held request");
      applyReset();
      e.inv = 1'b0; e.invAddr = 16'h0000;
      e.port = 1'b0; e.data = 16'h1234; sb.push_back(e);
      e.port = 1'b1; e.data = 16'hBEEF; sb.push_back(e);
      req0 = {1'b0, 16'h0000, 16'h0202};
      req1 = {1'b0, 16'h0000, 16'h0010};
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      cyc0 = 0; cyc1 = 0; pulses0 = 0; pulses1 = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clock); #1;
         if (respRdy0) begin pulses0++; if (cyc0 == 0) cyc0 = i; end
         if (respRdy1) begin pulses1++; if (cyc1 == 0) cyc1 = i; end
      end
      checkOutput("simCyc0",    cyc0,    32'd3);
      checkOutput("simCyc1",    cyc1,    32'd7);
      checkOutput("simPulses0", pulses0, 32'd1);
      checkOutput("simPulses1", pulses1, 32'd1);
      pulses0 = 0; pulses1 = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         if (respRdy0) pulses0++;
         if (respRdy1) pulses1++;
      end
      checkOutput("heldPulses0", pulses0, 32'd0);
      checkOutput("heldPulses1", pulses1, 32'd0);
      rdy0 = 1'b0;
      @(posedge clock); #1;
      e.port = 1'b0; e.data = 16'h1234; sb.push_back(e);
      rdy0 = 1'b1;
      pulses0 = 0; pulses1 = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock); #1;
         if (respRdy0) pulses0++;
         if (respRdy1) pulses1++;
      end
      checkOutput("rearmPulses0", pulses0, 32'd1);
      checkOutput("rearmPulses1", pulses1, 32'd0);
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      @(posedge clock); #1;

      $display("[TB] fairness");
      applyReset();
      for (int k = 0; k < 6; k++) begin
         e.port = k[0];
         e.data = k[0] ? 16'hBEEF : 16'h1234;
         sb.push_back(e);
         order[k] = -1;
      end
      req0 = {1'b0, 16'h0000, 16'h0202};
      req1 = {1'b0, 16'h0000, 16'h0010};
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      served = 0; s0 = 0; s1 = 0;
      for (int i = 0; i < 60 && served < 6; i++) begin
         @(posedge clock); #1;
         if (respRdy0) begin
            if (served < 6) order[served] = 0;
            served++; s0++; rdy0 = 1'b0;
         end else if (!rdy0 && s0 < 3) begin
            rdy0 = 1'b1;
         end
         if (respRdy1) begin
            if (served < 6) order[served] = 1;
            served++; s1++; rdy1 = 1'b0;
         end else if (!rdy1 && s1 < 3) begin
            rdy1 = 1'b1;
         end
      end
      checkOutput("fairCount", served, 32'd6);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("fairOrder%0d", k), order[k], k % 2);
      end
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      @(posedge clock); #1;

      $display("[TB] reset during BUSY");
      applyStimulus(1'b1, 1'b1, 16'h5555, 16'h0004, 16'h5555);
      req1 = {1'b1, 16'hAAAA, 16'h0004};
      rdy1 = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      checkAllZero("midReset");
      @(posedge clock); #1;
      rdy1  = 1'b0;
      reset = 1'b0;
      pulses0 = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (respRdy0 || respRdy1 || invValid0 || invValid1) pulses0++;
      end
      checkOutput("noPulseAfterReset", pulses0, 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0004, 16'h5555);
      checkOutput("postResetRead", {16'd0, resp0}, 32'h00005555);

      checkOutput("queueDrained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
